frame_deserializer: RTL and testbench



---
 rtl/frame_deserializer_if.sv | 32 +++
 rtl/frame_deserializer.sv | 146 ++++++++++++++
 tb/tb_frame_deserializer.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_deserializer_if.sv
// Handshake/bus bundle for frame_deserializer: beat input side, frame output side and status.
// slave = the deserializer, master = the producer/consumer driving it.
interface frame_deserializer_if #(
    parameter int IN_W      = 8,
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4
);
    localparam int FRAME_W = WORD_W * NUM_WORDS;
    localparam int BEATS   = FRAME_W / IN_W;
    localparam int CNT_W   = $clog2(BEATS + 2);

    logic [IN_W-1:0]    in_data;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [FRAME_W-1:0] frame_data;
    logic               frame_valid;
    logic               frame_ready;
    logic [CNT_W-1:0]   beat_count;
    logic               overrun;
    logic               chk_err;

    modport slave (
        input  in_data, in_valid, flush, frame_ready,
        output in_ready, frame_data, frame_valid, beat_count, overrun, chk_err
    );

    modport master (
        output in_data, in_valid, flush, frame_ready,
        input  in_ready, frame_data, frame_valid, beat_count, overrun, chk_err
    );
endinterface

// File: rtl/frame_deserializer.sv
// Collects IN_W-bit beats into a FRAME_W-bit frame with an assembly register and an output holding register.
// Optional trailing XOR checksum beat per frame when FRAME_CHECKSUM_EN is defined.
//
// state | meaning
// FILL  | accepting beats into the assembly register
// FULL  | assembly complete, waiting for the holding register to free up
module frame_deserializer #(
    parameter int IN_W      = 8,
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4
) (
    input logic                  clk,
    input logic                  write_data_reset,
    frame_deserializer_if.slave  bus
);
    localparam int FRAME_W = WORD_W * NUM_WORDS;
    localparam int BEATS   = FRAME_W / IN_W;
    localparam int CNT_W   = $clog2(BEATS + 2);
`ifdef FRAME_CHECKSUM_EN
    localparam int TOTAL   = BEATS + 1;
`else
    localparam int TOTAL   = BEATS;
`endif
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TOTAL);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(BEATS);

    typedef enum logic {S_FILL = 1'b0, S_FULL = 1'b1} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [FRAME_W-1:0] asm_q;
    logic [FRAME_W-1:0] hold_q;
    logic               fv_q;
    logic               ovr_q;

    logic [FRAME_W-1:0] asm_d;
    logic               accept;
    logic               consume;
    logic               last_beat;
    logic               load_new;
    logic               go_full;
    logic               load_pend;

    assign bus.in_ready = (state_q == S_FILL);

    always_comb begin
        accept    = bus.in_valid && bus.in_ready && !bus.flush;
        consume   = fv_q && bus.frame_ready;
        last_beat = accept && (cnt_q == LAST_IDX);
        // Only data beats enter the assembly; a trailing checksum beat sits at index BEATS.
        asm_d     = asm_q;
        if (accept && (cnt_q < DATA_CNT)) begin
            asm_d = {asm_q[FRAME_W-IN_W-1:0], bus.in_data};
        end
        load_new  = last_beat && (!fv_q || consume);
        go_full   = last_beat && fv_q && !consume;
        load_pend = (state_q == S_FULL) && consume && !bus.flush;
    end

    always_ff @(posedge clk or posedge write_data_reset) begin
        if (write_data_reset) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            asm_q   <= '0;
            hold_q  <= '0;
            fv_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= bus.flush ? 1'b0 : (ovr_q | (bus.in_valid & ~bus.in_ready));
            if (bus.flush) begin
                state_q <= S_FILL;
                cnt_q   <= '0;
                if (consume) begin
                    fv_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_FILL: begin
                        asm_q <= asm_d;
                        if (load_new) begin
                            hold_q <= asm_d;
                            fv_q   <= 1'b1;
                            cnt_q  <= '0;
                        end else if (go_full) begin
                            state_q <= S_FULL;
                            cnt_q   <= FULL_CNT;
                        end else begin
                            if (accept) begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                            if (consume) begin
                                fv_q <= 1'b0;
                            end
                        end
                    end
                    S_FULL: begin
                        // Holding register is swapped in place, so frame_valid stays high.
                        if (load_pend) begin
                            hold_q  <= asm_q;
                            state_q <= S_FILL;
                            cnt_q   <= '0;
                        end
                    end
                    default: state_q <= S_FILL;
                endcase
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [IN_W-1:0] xor_q;
    logic            pend_err_q;
    logic            chk_q;

    always_ff @(posedge clk or posedge write_data_reset) begin
        if (write_data_reset) begin
            xor_q      <= '0;
            pend_err_q <= 1'b0;
            chk_q      <= 1'b0;
        end else if (bus.flush) begin
            xor_q <= '0;
        end else if (last_beat) begin
            xor_q <= '0;
            if (load_new) begin
                chk_q <= (xor_q != bus.in_data);
            end else begin
                pend_err_q <= (xor_q != bus.in_data);
            end
        end else if (accept) begin
            xor_q <= xor_q ^ bus.in_data;
        end else if (load_pend) begin
            chk_q <= pend_err_q;
        end
    end

    assign bus.chk_err = chk_q;
`else
    assign bus.chk_err = 1'b0;
`endif

    assign bus.frame_data  = hold_q;
    assign bus.frame_valid = fv_q;
    assign bus.beat_count  = cnt_q;
    assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_frame_deserializer.sv
// Self-checking bench for frame_deserializer: transaction-level model (beat queue, pending frame, held frame)
// compared every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_frame_deserializer;
    localparam int IN_W = 8, WORD_W = 32, NUM_WORDS = 4;
    localparam int FRAME_W = WORD_W * NUM_WORDS;
    localparam int BEATS = FRAME_W / IN_W;
`ifdef FRAME_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif
    localparam int TOTAL = CHK ? BEATS + 1 : BEATS;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_deserializer_if #(.IN_W(IN_W), .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) bus ();

    frame_deserializer #(.IN_W(IN_W), .WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS)) dut (
        .clk              (clk),
        .write_data_reset (rst),
        .bus              (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [FRAME_W-1:0] act, input logic [FRAME_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [IN_W-1:0]    part_q[$];
    bit                 m_pend, m_fv, m_ovr, m_pend_err, m_held_err;
    logic [FRAME_W-1:0] m_pend_data, m_held;

    task automatic model_step();
        bit rdy, consume, err;
        logic [FRAME_W-1:0] d;
        logic [IN_W-1:0] x;
        rdy = !m_pend;
        consume = m_fv && bus.frame_ready;
        if (bus.flush) begin
            part_q.delete();
            m_pend = 1'b0;
            m_ovr  = 1'b0;
            if (consume) m_fv = 1'b0;
        end else begin
            if (bus.in_valid && !rdy) m_ovr = 1'b1;
            if (m_pend) begin
                if (consume) begin
                    m_held = m_pend_data;
                    m_held_err = m_pend_err;
                    m_pend = 1'b0;
                end
            end else if (bus.in_valid) begin
                part_q.push_back(bus.in_data);
                if (part_q.size() == TOTAL) begin
                    d = '0;
                    x = '0;
                    for (int i = 0; i < BEATS; i++) begin
                        d = (d << IN_W) | FRAME_W'(part_q[i]);
                        x = x ^ part_q[i];
                    end
                    err = CHK ? (x != part_q[TOTAL-1]) : 1'b0;
                    part_q.delete();
                    if (!m_fv || consume) begin
                        m_held = d;
                        m_held_err = err;
                        m_fv = 1'b1;
                    end else begin
                        m_pend_data = d;
                        m_pend_err = err;
                        m_pend = 1'b1;
                    end
                end else if (consume) begin
                    m_fv = 1'b0;
                end
            end else if (consume) begin
                m_fv = 1'b0;
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            part_q.delete();
            m_pend = 1'b0; m_fv = 1'b0; m_ovr = 1'b0;
            m_pend_err = 1'b0; m_held_err = 1'b0;
            m_pend_data = '0; m_held = '0;
        end else begin
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_en && !rst) begin
            chk("in_ready", FRAME_W'(bus.in_ready), FRAME_W'(!m_pend));
            chk("beat_count", FRAME_W'(bus.beat_count), FRAME_W'(m_pend ? TOTAL : part_q.size()));
            chk("overrun", FRAME_W'(bus.overrun), FRAME_W'(m_ovr));
            chk("frame_valid", FRAME_W'(bus.frame_valid), FRAME_W'(m_fv));
            chk("frame_data", bus.frame_data, m_held);
            if (m_fv) chk("chk_err", FRAME_W'(bus.chk_err), FRAME_W'(m_held_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input bit v, input logic [IN_W-1:0] d, input bit fr, input bit fl);
        bus.in_valid = v;
        bus.in_data = d;
        bus.frame_ready = fr;
        bus.flush = fl;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [IN_W-1:0] base, input bit fr, input bit gap, input bit bad);
        logic [IN_W-1:0] x;
        logic [IN_W-1:0] d;
        x = '0;
        for (int i = 0; i < BEATS; i++) begin
            d = base + IN_W'(i);
            x = x ^ d;
            cyc(1'b1, d, fr, 1'b0);
            if (gap) cyc(1'b0, IN_W'($urandom), fr, 1'b0);
        end
        if (CHK) cyc(1'b1, x ^ IN_W'(bad), fr, 1'b0);
    endtask

    logic [FRAME_W-1:0] first_frame;

    initial begin
        bus.in_valid = 1'b0; bus.in_data = '0; bus.frame_ready = 1'b0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_frame_valid", FRAME_W'(bus.frame_valid), '0);
        chk("rst_beat_count", FRAME_W'(bus.beat_count), '0);
        chk("rst_overrun", FRAME_W'(bus.overrun), '0);
        chk("rst_frame_data", bus.frame_data, '0);
        rst = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", FRAME_W'(bus.in_ready), FRAME_W'(1));

        // continuous stream, consumer ready
        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        chk("t1_valid", FRAME_W'(bus.frame_valid), FRAME_W'(1));
        chk("t1_word3", FRAME_W'(bus.frame_data[127:96]), FRAME_W'(32'h00010203));
        chk("t1_word0", FRAME_W'(bus.frame_data[31:0]), FRAME_W'(32'h0C0D0E0F));
        chk("t1_in_ready", FRAME_W'(bus.in_ready), FRAME_W'(1));
        if (CHK) chk("t1_chk_err", FRAME_W'(bus.chk_err), '0);
        first_frame = bus.frame_data;
        cyc(1'b0, '0, 1'b1, 1'b0);

        // consumer stalled: second frame parks in assembly
        send_frame(8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(8'h10, 1'b0, 1'b0, 1'b0);
        chk("t2_in_ready_low", FRAME_W'(bus.in_ready), '0);
        chk("t2_beat_count", FRAME_W'(bus.beat_count), FRAME_W'(TOTAL));
        chk("t2_first_held", FRAME_W'(bus.frame_data[127:96]), FRAME_W'(32'h00010203));
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t2_valid", FRAME_W'(bus.frame_valid), FRAME_W'(1));
        chk("t2_word3", FRAME_W'(bus.frame_data[127:96]), FRAME_W'(32'h10111213));
        chk("t2_in_ready", FRAME_W'(bus.in_ready), FRAME_W'(1));
        cyc(1'b0, '0, 1'b1, 1'b0);

        // in_valid toggled every other cycle
        send_frame(8'h00, 1'b0, 1'b1, 1'b0);
        chk("t3_same_frame", bus.frame_data, first_frame);
        cyc(1'b0, '0, 1'b1, 1'b0);

        // 5 beats, flush, then a clean frame
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h55, 1'b0, 1'b0);
        chk("t4_count5", FRAME_W'(bus.beat_count), FRAME_W'(5));
        cyc(1'b1, 8'h77, 1'b0, 1'b1);
        chk("t4_flushed", FRAME_W'(bus.beat_count), '0);
        send_frame(8'hA0, 1'b0, 1'b0, 1'b0);
        chk("t4_word3", FRAME_W'(bus.frame_data[127:96]), FRAME_W'(32'hA0A1A2A3));
        chk("t4_word0", FRAME_W'(bus.frame_data[31:0]), FRAME_W'(32'hACADAEAF));
        cyc(1'b0, '0, 1'b1, 1'b0);

        // overrun while FULL, survives a consume, cleared by flush
        send_frame(8'h20, 1'b0, 1'b0, 1'b0);
        send_frame(8'h30, 1'b0, 1'b0, 1'b0);
        chk("t5_no_ovr", FRAME_W'(bus.overrun), '0);
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        chk("t5_ovr_set", FRAME_W'(bus.overrun), FRAME_W'(1));
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("t5_ovr_sticky", FRAME_W'(bus.overrun), FRAME_W'(1));
        chk("t5_word3", FRAME_W'(bus.frame_data[127:96]), FRAME_W'(32'h30313233));
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("t5_ovr_clr", FRAME_W'(bus.overrun), '0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        if (CHK) begin
            send_frame(8'h00, 1'b1, 1'b0, 1'b1);
            chk("t6_chk_err", FRAME_W'(bus.chk_err), FRAME_W'(1));
            chk("t6_same_data", bus.frame_data, first_frame);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end

        // reset mid-frame with a frame held
        send_frame(8'h40, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 8'h99, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("t7_fv", FRAME_W'(bus.frame_valid), '0);
        chk("t7_bc", FRAME_W'(bus.beat_count), '0);
        chk("t7_ir", FRAME_W'(bus.in_ready), FRAME_W'(1));
        chk("t7_data", bus.frame_data, '0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 3) != 0), IN_W'($urandom),
                (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 60) == 0));
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
